// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, frame
// geometry, default timing and the frame builder.
package ps2_host_tx_pkg;

  localparam int FRAME_LEN       = 11;
  localparam int TIMER_W         = 20;
  localparam int DEF_INHIBIT_CYC = 5500;
  localparam int DEF_START_TMO   = 750000;
  localparam int DEF_XFER_TMO    = 100000;
  localparam int DEF_FILT_LEN    = 8;

  typedef logic [7:0] ps2_byte_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAITREL,
    S_END,
    S_FAIL
  } state_t;

  // {stop, odd parity, data}; shifted out LSB first
  function automatic logic [9:0] build_frame(input ps2_byte_t data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/status handshake between the CPU-side requester and the PS/2
// host transmitter.
interface ps2_host_tx_if;
  import ps2_host_tx_pkg::*;

  ps2_byte_t tx_data;
  logic      tx_start;
  logic      busy;
  logic      done;
  logic      ack_err;
  logic      tmo_err;

  modport master (
    output tx_data, tx_start,
    input  busy, done, ack_err, tmo_err
  );

  modport slave (
    input  tx_data, tx_start,
    output busy, done, ack_err, tmo_err
  );

endinterface

// File: rtl/ps2_host_tx_filter.sv
// Two-flop synchroniser plus debounce: a new line level is accepted only
// after FILT_LEN consecutive samples agree. Idles high like the bus.
module ps2_line_filter
  import ps2_host_tx_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic clock,
  input  logic reset,
  input  logic i_line,
  output logic o_level
);

  localparam int            CW   = $clog2(FILT_LEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          w_diff;

  assign w_diff  = r_sync[1] ^ r_level;
  assign o_level = r_level;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_line};
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts
// one byte out on device-generated clocks and checks the device ACK bit.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
  parameter int START_TMO   = DEF_START_TMO,
  parameter int XFER_TMO    = DEF_XFER_TMO,
  parameter int FILT_LEN    = DEF_FILT_LEN
) (
  input  logic         clock,
  input  logic         reset,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_i,
  input  logic         ps2_dat_i,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(INHIBIT_CYC - 1);
  localparam logic [TIMER_W-1:0] START_LIM  = TIMER_W'(START_TMO);
  localparam logic [TIMER_W-1:0] XFER_LIM   = TIMER_W'(XFER_TMO);
  localparam logic [3:0]         LAST_SHIFT = 4'(FRAME_LEN - 2);

  state_t             r_state, w_next;
  logic [TIMER_W-1:0] r_timer;
  logic [3:0]         r_bitcnt;
  logic [9:0]         r_shift;
  logic               r_dat_drv;
  logic               r_nack;
  logic               r_clk_prev;
  logic               w_clk_f, w_dat_f, w_fall;
  logic               w_timer_clr, w_load, w_shift, w_set_nack, w_xfer_tmo;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clock   (clock),
    .reset   (reset),
    .i_line  (ps2_clk_i),
    .o_level (w_clk_f)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clock   (clock),
    .reset   (reset),
    .i_line  (ps2_dat_i),
    .o_level (w_dat_f)
  );

  assign w_fall     = r_clk_prev & ~w_clk_f;
  assign w_xfer_tmo = (r_timer > XFER_LIM);

  always_comb begin
    w_next      = r_state;
    w_timer_clr = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_set_nack  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.tx_start) begin
          w_load      = 1'b1;
          w_timer_clr = 1'b1;
          w_next      = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_timer == INH_LAST) w_next = S_START;
      end
      S_START: begin
        w_timer_clr = 1'b1;
        w_next      = S_REQ;
      end
      S_REQ: begin
        if (w_fall) begin
          w_shift     = 1'b1;
          w_timer_clr = 1'b1;
          w_next      = S_SHIFT;
        end else if (r_timer > START_LIM) begin
          w_next = S_FAIL;
        end
      end
      // Falls 2..10 put out the remaining frame bits; the tenth releases DAT
      S_SHIFT: begin
        if (w_xfer_tmo) begin
          w_next = S_FAIL;
        end else if (w_fall) begin
          w_shift = 1'b1;
          if (r_bitcnt == LAST_SHIFT) w_next = S_ACK;
        end
      end
      S_ACK: begin
        if (w_xfer_tmo) begin
          w_next = S_FAIL;
        end else if (w_fall) begin
          if (w_dat_f) begin
            w_set_nack = 1'b1;
            w_next     = S_FAIL;
          end else begin
            w_next = S_WAITREL;
          end
        end
      end
      S_WAITREL: begin
        if (w_xfer_tmo)             w_next = S_FAIL;
        else if (w_clk_f && w_dat_f) w_next = S_END;
      end
      S_END, S_FAIL: w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_dat_drv  <= 1'b0;
      r_nack     <= 1'b0;
      r_clk_prev <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_clk_prev <= w_clk_f;
      if (w_timer_clr)        r_timer <= '0;
      else if (r_timer != '1) r_timer <= r_timer + 1'b1;
      if (w_load) begin
        r_shift   <= build_frame(bus.tx_data);
        r_bitcnt  <= '0;
        r_dat_drv <= 1'b0;
        r_nack    <= 1'b0;
      end else if (w_shift) begin
        r_dat_drv <= ~r_shift[0];
        r_shift   <= {1'b0, r_shift[9:1]};
        r_bitcnt  <= r_bitcnt + 1'b1;
      end
      if (w_set_nack) r_nack <= 1'b1;
    end
  end

  // Outputs decode straight from the state so an async reset frees the bus at once
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_END) || (r_state == S_FAIL);
  assign bus.ack_err = (r_state == S_FAIL) && r_nack;
  assign bus.tmo_err = (r_state == S_FAIL) && !r_nack;
  assign ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_START);
  assign ps2_dat_oe  = (r_state == S_START) || (r_state == S_REQ) ||
                       ((r_state == S_SHIFT) && r_dat_drv);

endmodule
